vector_addition_sequencer: RTL and testbench
============================================

// Module: vector_addition_sequencer
// PURPOSE
//  Sequences one vector integer add/sub instruction over the 128-bit vector_addition_unit, one chunk at a time.
//  Accepts an issued instruction and reads vs1/vs2 chunks from the VRF.
//  Drives the adder with a per-chunk mask slice, then writes results back with byte enables.
//  Carry-compute ops (vmadc/vmsbc) accumulate mask bits and write them back once.
// PARAMETERS
//  VLEN     1024  bits per vector register; CHUNKS = VLEN/128 = 8
//  VL_W     8     width of vl; max vl = VLEN/8 = 128
// PORTS
//  clk_i               in   1    clock
//  rstn_i              in   1    asynchronous active-low reset
//  issue_valid_i       in   1    instruction valid
//  issue_ready_o       out  1    sequencer idle; issue accepted when valid&ready
//  vl_i                in   VL_W vector length in elements
//  vsew_i              in   2    00=8b 01=16b 10=32b 11=64b
//  vm_i                in   1    1=unmasked
//  reversed_i, add_sub_i, compute_carry_i, with_carry_borrow_i  in 1 each  op flags, passed to adder
//  vs1_addr_i, vs2_addr_i, vd_addr_i  in 5 each  register specifiers
//  vmask_i             in   VLEN/8  v0 contents, latched at issue
//  rd_req_o            out  1    VRF read strobe; data valid exactly 1 cycle later
//  rd_vs1_o, rd_vs2_o  out  5    read register specifiers
//  rd_chunk_o          out  3    chunk index
//  vs1_data_i, vs2_data_i  in 128  read data
//  add_request_o       out  1    adder request_i
//  add_vs1_o, add_vs2_o    out 128  adder operands
//  add_vmask_o         out  16   mask slice (vmask_i of adder)
//  add_vsew_o          out  2    plus the four op flags
//  add_vd_i            in   128  adder result (combinational)
//  wb_valid_o          out  1    writeback valid; held until wb_ready_i
//  wb_ready_i          in   1    VRF write accept
//  wb_vd_o             out  5    destination register
//  wb_chunk_o          out  3    destination chunk
//  wb_data_o           out  128  write data
//  wb_be_o             out  16   byte enables
//  done_o              out  1    one-cycle pulse at instruction completion
// BEHAVIOUR
//  Reset: state=IDLE; issue_ready_o=1; all other outputs 0; internal regs cleared.
//  FSM: IDLE -> READ -> EXEC -> WB -> (READ | IDLE).
//    Carry mode replaces WB with ACC; the last ACC -> CWB -> IDLE.
//  IDLE: on valid&ready, latch all issue fields and vmask; c=0.
//    epc = 16>>vsew; nchunks = ceil(vl/epc).
//    If vl==0: done_o pulses the next cycle, with no reads/writes, and FSM stays IDLE.
//  READ (1 cycle): rd_req_o=1, rd_chunk_o=c.
//  EXEC (1 cycle): add_request_o=1; operands = read data; add_vmask_o = (vmask>>(c*epc))[15:0].
//    Result is registered into res_q; add_request_o=0 in all other states.
//  WB: wb_valid_o=1, wb_data_o=res_q, wb_chunk_o=c; outputs stable until wb_ready_i.
//    On accept: if c==nchunks-1 -> IDLE with done_o pulse; else c++ -> READ.
//  wb_be_o: byte of element e enabled iff c*epc+e < vl
//    AND (vm or with_carry_borrow or mask bit e set).
//  ACC: carry_q[c*epc +: epc] = res_q[epc-1:0] (upper bits ignored); c++ or -> CWB.
//  CWB: wb_chunk_o=0; wb_data_o=carry_q with bits >= vl forced to 0; be = ceil(vl/8) low bytes.
//    On accept -> IDLE with done_o pulse.
//  Latency, non-carry: 3 cycles per chunk plus wb stall cycles; done_o follows the last accept.
//  issue_ready_o=1 only in IDLE; issue_valid_i ignored while busy.
//  rstn_i low mid-instruction: immediate abort, no further writes; operation not resumed.
// STRUCTURE
//  vector_defines.vh: `vsew_8b..`vsew_64b encodings, state localparams, CHUNK_W=128.
//  Sub-module vector_tail_mask_gen: (vl, vsew, chunk, mask slice, vm, wcb) -> wb_be_o; combinational.
//  FSM, chunk counter, res_q and carry_q live in this module.
// TESTING
//  vsew=8b, vl=16, vm=1, add: one chunk; wb_data=vs1+vs2 per byte; be=FFFF; done_o after 1 accept.
//  vsew=32b, vl=10: 3 chunks; last chunk be=00FF; chunk sequence 0,1,2; no read of chunk 3.
//  vsew=8b, vl=16, vm=0, v0=0x00AA: be=00AA (odd elements only).
//  vmadc, vsew=64b, vl=4, all elements carry: single write, chunk 0, data=0xF, be=0001.
//  wb_ready_i low 5 cycles: wb outputs stable throughout; vl=0 -> done_o only, no rd_req_o/wb_valid_o.
//  rstn_i low during EXEC of chunk 1: all outputs 0; next issue processed from chunk 0.

Source files
------------

// File: rtl/vector_addition_sequencer_pkg.sv
// Package for the vector add/sub sequencer.
// Holds the chunk geometry, SEW encodings, the FSM state type and a helper
// that converts an SEW encoding into the number of elements per 128-bit chunk.
package vector_addition_sequencer_pkg;

  localparam int CHUNK_W = 128;
  localparam int CHUNK_B = CHUNK_W / 8;

  localparam logic [1:0] VSEW_8B  = 2'b00;
  localparam logic [1:0] VSEW_16B = 2'b01;
  localparam logic [1:0] VSEW_32B = 2'b10;
  localparam logic [1:0] VSEW_64B = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_EXEC = 3'd2,
    ST_WB   = 3'd3,
    ST_ACC  = 3'd4,
    ST_CWB  = 3'd5
  } state_e;

  // Elements held in one chunk: 16 bytes split by element size.
  function automatic logic [4:0] elems_per_chunk(input logic [1:0] vsew);
    return 5'd16 >> vsew;
  endfunction

endpackage

// File: rtl/vector_addition_sequencer_tail_mask_gen.sv
// Byte-enable generator for one result chunk.
// A byte is enabled when its element index (chunk*epc + element) lies below
// vl and the element is active (unmasked op, carry/borrow-in op, or mask bit set).
// Ports:
//   vl_i     vector length in elements
//   vsew_i   element width encoding
//   chunk_i  chunk index being written
//   mask_i   v0 slice for this chunk, one bit per element
//   vm_i     1 = unmasked
//   wcb_i    with_carry_borrow: v0 is carry input, not a write mask
//   be_o     16 byte enables
module vector_addition_sequencer_tail_mask_gen
  import vector_addition_sequencer_pkg::*;
#(
  parameter int VL_W   = 8,
  parameter int CIDX_W = 3
) (
  input  logic [VL_W-1:0]    vl_i,
  input  logic [1:0]         vsew_i,
  input  logic [CIDX_W-1:0]  chunk_i,
  input  logic [CHUNK_B-1:0] mask_i,
  input  logic               vm_i,
  input  logic               wcb_i,
  output logic [CHUNK_B-1:0] be_o
);

  logic [VL_W:0] base;
  logic [2:0]    shamt;

  assign shamt = 3'd4 - {1'b0, vsew_i};
  assign base  = (VL_W+1)'(chunk_i) << shamt;

  always_comb begin
    logic [3:0]    elem;
    logic [VL_W:0] idx;
    be_o = '0;
    elem = '0;
    idx  = '0;
    for (int b = 0; b < CHUNK_B; b++) begin
      elem = 4'(b >> vsew_i);
      idx  = base + (VL_W+1)'(elem);
      if ((idx < {1'b0, vl_i}) && (vm_i || wcb_i || mask_i[elem])) begin
        be_o[b] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vector_addition_sequencer.sv
// Sequences one vector integer add/sub instruction over a 128-bit adder,
// one chunk at a time: READ (VRF strobe), EXEC (adder, result captured),
// WB (write back with byte enables). Carry-compute ops replace WB with ACC,
// collecting per-element carry bits, and write the mask once in CWB.
// Ports:
//   clk_i, rstn_i                  clock, asynchronous active-low reset
//   issue_*/vl_i/vsew_i/vm_i/...   instruction issue handshake and fields
//   vmask_i                        v0 contents, latched at issue
//   rd_*                           VRF read port (data valid one cycle later)
//   add_*                          adder request, operands, mask slice, flags
//   add_vd_i                       adder result (combinational)
//   wb_*                           VRF write port, held until wb_ready_i
//   done_o                         one-cycle completion pulse
module vector_addition_sequencer
  import vector_addition_sequencer_pkg::*;
#(
  parameter int VLEN = 1024,
  parameter int VL_W = 8
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      issue_valid_i,
  output logic                      issue_ready_o,
  input  logic [VL_W-1:0]           vl_i,
  input  logic [1:0]                vsew_i,
  input  logic                      vm_i,
  input  logic                      reversed_i,
  input  logic                      add_sub_i,
  input  logic                      compute_carry_i,
  input  logic                      with_carry_borrow_i,
  input  logic [4:0]                vs1_addr_i,
  input  logic [4:0]                vs2_addr_i,
  input  logic [4:0]                vd_addr_i,
  input  logic [VLEN/8-1:0]         vmask_i,
  output logic                      rd_req_o,
  output logic [4:0]                rd_vs1_o,
  output logic [4:0]                rd_vs2_o,
  output logic [$clog2(VLEN/CHUNK_W)-1:0] rd_chunk_o,
  input  logic [CHUNK_W-1:0]        vs1_data_i,
  input  logic [CHUNK_W-1:0]        vs2_data_i,
  output logic                      add_request_o,
  output logic [CHUNK_W-1:0]        add_vs1_o,
  output logic [CHUNK_W-1:0]        add_vs2_o,
  output logic [CHUNK_B-1:0]        add_vmask_o,
  output logic [1:0]                add_vsew_o,
  output logic                      add_reversed_o,
  output logic                      add_add_sub_o,
  output logic                      add_compute_carry_o,
  output logic                      add_with_carry_borrow_o,
  input  logic [CHUNK_W-1:0]        add_vd_i,
  output logic                      wb_valid_o,
  input  logic                      wb_ready_i,
  output logic [4:0]                wb_vd_o,
  output logic [$clog2(VLEN/CHUNK_W)-1:0] wb_chunk_o,
  output logic [CHUNK_W-1:0]        wb_data_o,
  output logic [CHUNK_B-1:0]        wb_be_o,
  output logic                      done_o
);

  localparam int MASK_W = VLEN / 8;
  localparam int CIDX_W = $clog2(VLEN / CHUNK_W);
  localparam int MB_W   = $clog2(MASK_W);

  state_e              state_q, state_d;
  logic [CIDX_W-1:0]   chunk_q, chunk_d;
  logic [VL_W:0]       nchunks_q, nchunks_d;
  logic [VL_W-1:0]     vl_q, vl_d;
  logic [1:0]          vsew_q, vsew_d;
  logic                vm_q, vm_d;
  logic                rev_q, rev_d;
  logic                addsub_q, addsub_d;
  logic                cc_q, cc_d;
  logic                wcb_q, wcb_d;
  logic [4:0]          vs1_q, vs1_d;
  logic [4:0]          vs2_q, vs2_d;
  logic [4:0]          vd_q, vd_d;
  logic [MASK_W-1:0]   vmask_q, vmask_d;
  logic [CHUNK_W-1:0]  res_q, res_d;
  logic [MASK_W-1:0]   carry_q, carry_d;
  logic                done_q, done_d;

  logic [4:0]          epc_in, epc;
  logic [VL_W:0]       nch_in;
  logic [2:0]          shamt;
  logic [MB_W-1:0]     base;
  logic [CHUNK_B-1:0]  mask_slice;
  logic                last_chunk;
  logic [CHUNK_B-1:0]  be_wb;
  logic [CHUNK_B-1:0]  be_cwb;
  logic [MASK_W-1:0]   carry_tail;
  logic [4:0]          cwb_nbytes;

  // Element count is a power of two, so ceil(vl/epc) reduces to a shift.
  assign epc_in = elems_per_chunk(vsew_i);
  assign nch_in = ({1'b0, vl_i} + (VL_W+1)'(epc_in) - (VL_W+1)'(1))
                  >> (3'd4 - {1'b0, vsew_i});

  assign epc        = elems_per_chunk(vsew_q);
  assign shamt      = 3'd4 - {1'b0, vsew_q};
  assign base       = MB_W'(chunk_q) << shamt;
  assign mask_slice = CHUNK_B'(vmask_q >> base);
  assign last_chunk = ((VL_W+1)'(chunk_q) == (nchunks_q - (VL_W+1)'(1)));

  vector_addition_sequencer_tail_mask_gen #(
    .VL_W   (VL_W),
    .CIDX_W (CIDX_W)
  ) u_tail_mask_gen (
    .vl_i    (vl_q),
    .vsew_i  (vsew_q),
    .chunk_i (chunk_q),
    .mask_i  (mask_slice),
    .vm_i    (vm_q),
    .wcb_i   (wcb_q),
    .be_o    (be_wb)
  );

  // Carry mask write: zero the bits past vl, enable ceil(vl/8) bytes.
  assign cwb_nbytes = 5'(({1'b0, vl_q} + (VL_W+1)'(7)) >> 3);

  always_comb begin
    carry_tail = '0;
    for (int i = 0; i < MASK_W; i++) begin
      carry_tail[i] = carry_q[i] & (i < int'(vl_q));
    end
    be_cwb = '0;
    for (int b = 0; b < CHUNK_B; b++) begin
      be_cwb[b] = (b < int'(cwb_nbytes));
    end
  end

  always_comb begin
    logic [MB_W-1:0] cidx;
    state_d   = state_q;
    chunk_d   = chunk_q;
    nchunks_d = nchunks_q;
    vl_d      = vl_q;
    vsew_d    = vsew_q;
    vm_d      = vm_q;
    rev_d     = rev_q;
    addsub_d  = addsub_q;
    cc_d      = cc_q;
    wcb_d     = wcb_q;
    vs1_d     = vs1_q;
    vs2_d     = vs2_q;
    vd_d      = vd_q;
    vmask_d   = vmask_q;
    res_d     = res_q;
    carry_d   = carry_q;
    done_d    = 1'b0;
    cidx      = '0;
    case (state_q)
      ST_IDLE: begin
        if (issue_valid_i) begin
          vl_d      = vl_i;
          vsew_d    = vsew_i;
          vm_d      = vm_i;
          rev_d     = reversed_i;
          addsub_d  = add_sub_i;
          cc_d      = compute_carry_i;
          wcb_d     = with_carry_borrow_i;
          vs1_d     = vs1_addr_i;
          vs2_d     = vs2_addr_i;
          vd_d      = vd_addr_i;
          vmask_d   = vmask_i;
          nchunks_d = nch_in;
          chunk_d   = '0;
          carry_d   = '0;
          // Empty instruction completes without touching the VRF.
          if (vl_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: begin
        res_d   = add_vd_i;
        state_d = cc_q ? ST_ACC : ST_WB;
      end
      ST_WB: begin
        if (wb_ready_i) begin
          if (last_chunk) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            chunk_d = chunk_q + CIDX_W'(1);
            state_d = ST_READ;
          end
        end
      end
      ST_ACC: begin
        // Adder returns one carry bit per element in the low epc bits.
        for (int j = 0; j < CHUNK_B; j++) begin
          cidx = base + MB_W'(j);
          if (j < int'(epc)) begin
            carry_d[cidx] = res_q[j];
          end
        end
        if (last_chunk) begin
          state_d = ST_CWB;
        end else begin
          chunk_d = chunk_q + CIDX_W'(1);
          state_d = ST_READ;
        end
      end
      ST_CWB: begin
        if (wb_ready_i) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= ST_IDLE;
      chunk_q   <= '0;
      nchunks_q <= '0;
      vl_q      <= '0;
      vsew_q    <= '0;
      vm_q      <= 1'b0;
      rev_q     <= 1'b0;
      addsub_q  <= 1'b0;
      cc_q      <= 1'b0;
      wcb_q     <= 1'b0;
      vs1_q     <= '0;
      vs2_q     <= '0;
      vd_q      <= '0;
      vmask_q   <= '0;
      res_q     <= '0;
      carry_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      chunk_q   <= chunk_d;
      nchunks_q <= nchunks_d;
      vl_q      <= vl_d;
      vsew_q    <= vsew_d;
      vm_q      <= vm_d;
      rev_q     <= rev_d;
      addsub_q  <= addsub_d;
      cc_q      <= cc_d;
      wcb_q     <= wcb_d;
      vs1_q     <= vs1_d;
      vs2_q     <= vs2_d;
      vd_q      <= vd_d;
      vmask_q   <= vmask_d;
      res_q     <= res_d;
      carry_q   <= carry_d;
      done_q    <= done_d;
    end
  end

  // Outputs decode only from flops (plus read data passed to the adder in EXEC).
  assign issue_ready_o = (state_q == ST_IDLE);

  assign rd_req_o   = (state_q == ST_READ);
  assign rd_vs1_o   = rd_req_o ? vs1_q : '0;
  assign rd_vs2_o   = rd_req_o ? vs2_q : '0;
  assign rd_chunk_o = rd_req_o ? chunk_q : '0;

  assign add_request_o           = (state_q == ST_EXEC);
  assign add_vs1_o               = add_request_o ? vs1_data_i : '0;
  assign add_vs2_o               = add_request_o ? vs2_data_i : '0;
  assign add_vmask_o             = add_request_o ? mask_slice : '0;
  assign add_vsew_o              = add_request_o ? vsew_q : '0;
  assign add_reversed_o          = add_request_o & rev_q;
  assign add_add_sub_o           = add_request_o & addsub_q;
  assign add_compute_carry_o     = add_request_o & cc_q;
  assign add_with_carry_borrow_o = add_request_o & wcb_q;

  assign wb_valid_o = (state_q == ST_WB) || (state_q == ST_CWB);
  assign wb_vd_o    = wb_valid_o ? vd_q : '0;
  assign wb_chunk_o = (state_q == ST_WB) ? chunk_q : '0;
  assign wb_data_o  = (state_q == ST_WB)  ? res_q :
                      (state_q == ST_CWB) ? CHUNK_W'(carry_tail) : '0;
  assign wb_be_o    = (state_q == ST_WB)  ? be_wb :
                      (state_q == ST_CWB) ? be_cwb : '0;

  assign done_o = done_q;

endmodule

// File: tb/tb_vector_addition_sequencer.sv
// Directed bench for vector_addition_sequencer: a tiny VRF and adder model
// respond to the DUT, a negedge monitor logs traffic, and each test compares
// the logs against hand-computed values.
module tb_vector_addition_sequencer;

  logic         clk_i = 1'b0;
  logic         rstn_i;
  logic         issue_valid_i, issue_ready_o;
  logic [7:0]   vl_i;
  logic [1:0]   vsew_i;
  logic         vm_i, reversed_i, add_sub_i, compute_carry_i, with_carry_borrow_i;
  logic [4:0]   vs1_addr_i, vs2_addr_i, vd_addr_i;
  logic [127:0] vmask_i;
  logic         rd_req_o;
  logic [4:0]   rd_vs1_o, rd_vs2_o;
  logic [2:0]   rd_chunk_o;
  logic [127:0] vs1_data_i, vs2_data_i;
  logic         add_request_o;
  logic [127:0] add_vs1_o, add_vs2_o;
  logic [15:0]  add_vmask_o;
  logic [1:0]   add_vsew_o;
  logic         add_reversed_o, add_add_sub_o, add_compute_carry_o, add_with_carry_borrow_o;
  logic [127:0] add_vd_i;
  logic         wb_valid_o, wb_ready_i;
  logic [4:0]   wb_vd_o;
  logic [2:0]   wb_chunk_o;
  logic [127:0] wb_data_o;
  logic [15:0]  wb_be_o;
  logic         done_o;

  always #5 clk_i = ~clk_i;

  vector_addition_sequencer #(.VLEN(1024), .VL_W(8)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .vl_i(vl_i), .vsew_i(vsew_i), .vm_i(vm_i),
    .reversed_i(reversed_i), .add_sub_i(add_sub_i),
    .compute_carry_i(compute_carry_i), .with_carry_borrow_i(with_carry_borrow_i),
    .vs1_addr_i(vs1_addr_i), .vs2_addr_i(vs2_addr_i), .vd_addr_i(vd_addr_i),
    .vmask_i(vmask_i),
    .rd_req_o(rd_req_o), .rd_vs1_o(rd_vs1_o), .rd_vs2_o(rd_vs2_o), .rd_chunk_o(rd_chunk_o),
    .vs1_data_i(vs1_data_i), .vs2_data_i(vs2_data_i),
    .add_request_o(add_request_o), .add_vs1_o(add_vs1_o), .add_vs2_o(add_vs2_o),
    .add_vmask_o(add_vmask_o), .add_vsew_o(add_vsew_o),
    .add_reversed_o(add_reversed_o), .add_add_sub_o(add_add_sub_o),
    .add_compute_carry_o(add_compute_carry_o),
    .add_with_carry_borrow_o(add_with_carry_borrow_o),
    .add_vd_i(add_vd_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_vd_o(wb_vd_o),
    .wb_chunk_o(wb_chunk_o), .wb_data_o(wb_data_o), .wb_be_o(wb_be_o),
    .done_o(done_o)
  );

  // VRF contents: register 8 is all ones, others byte k = k + 16*reg + chunk.
  function automatic logic [127:0] vrf_val(input logic [4:0] r, input logic [2:0] c);
    logic [127:0] v;
    v = '0;
    for (int k = 0; k < 16; k++) begin
      v[k*8 +: 8] = (r == 5'd8) ? 8'hFF : 8'(k + 16 * int'(r) + int'(c));
    end
    return v;
  endfunction

  // Reference adder: per-element ripple add/sub, or carry/borrow-out bits.
  function automatic logic [127:0] adder_model(input logic [127:0] a, input logic [127:0] b,
                                               input logic [1:0] sew, input logic sub,
                                               input logic rev, input logic cc);
    logic [127:0] r, out, x, y;
    logic         c, ai, bi;
    logic [6:0]   bidx;
    int           esz, n;
    esz = 8 << sew;
    n   = 128 / esz;
    r   = '0;
    out = '0;
    x   = rev ? b : a;
    y   = rev ? a : b;
    for (int e = 0; e < n; e++) begin
      c = sub;
      for (int i = 0; i < esz; i++) begin
        bidx    = 7'(e * esz + i);
        ai      = x[bidx];
        bi      = y[bidx] ^ sub;
        r[bidx] = ai ^ bi ^ c;
        c       = (ai & bi) | (c & (ai ^ bi));
      end
      out[7'(e)] = sub ? ~c : c;
    end
    return cc ? out : r;
  endfunction

  logic [4:0] rd_vs1_l = '0, rd_vs2_l = '0;
  logic [2:0] rd_chunk_l = '0;

  assign vs1_data_i = vrf_val(rd_vs1_l, rd_chunk_l);
  assign vs2_data_i = vrf_val(rd_vs2_l, rd_chunk_l);
  assign add_vd_i   = adder_model(add_vs1_o, add_vs2_o, add_vsew_o, add_add_sub_o,
                                  add_reversed_o, add_compute_carry_o);

  int           n_rd = 0, n_wb = 0, n_done = 0;
  logic [2:0]   rd_chunk_log[$];
  logic [2:0]   wb_chunk_log[$];
  logic [127:0] wb_data_log[$];
  logic [15:0]  wb_be_log[$];
  logic [4:0]   wb_vd_log[$];
  logic [15:0]  vmask_log[$];

  always @(negedge clk_i) begin
    if (rd_req_o) begin
      rd_vs1_l   = rd_vs1_o;
      rd_vs2_l   = rd_vs2_o;
      rd_chunk_l = rd_chunk_o;
      rd_chunk_log.push_back(rd_chunk_o);
      n_rd++;
    end
    if (add_request_o) vmask_log.push_back(add_vmask_o);
    if (wb_valid_o && wb_ready_i) begin
      wb_chunk_log.push_back(wb_chunk_o);
      wb_data_log.push_back(wb_data_o);
      wb_be_log.push_back(wb_be_o);
      wb_vd_log.push_back(wb_vd_o);
      n_wb++;
    end
    if (done_o) n_done++;
  end

  int n_chk = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [7:0] vl, input logic [1:0] sew, input logic vm,
                       input logic cc, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [4:0] d, input logic [127:0] mask);
    @(posedge clk_i); #1;
    vl_i = vl; vsew_i = sew; vm_i = vm; compute_carry_i = cc;
    vs1_addr_i = s1; vs2_addr_i = s2; vd_addr_i = d; vmask_i = mask;
    issue_valid_i = 1'b1;
    @(posedge clk_i); #1;
    issue_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int k;
    k = 0;
    while (n_done < target && k < budget) begin
      @(posedge clk_i);
      k++;
    end
    chk("done_seen", 128'(n_done >= target), 128'd1);
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  localparam logic [127:0] EXP_ADD8  = 128'h4E4C4A48464442403E3C3A3836343230;
  localparam logic [127:0] EXP_ADD32 = 128'h52504E4C4A48464442403E3C3A383634;

  initial begin
    int b_rd, b_wb, b_done, k;
    rstn_i = 1'b0; issue_valid_i = 1'b0; vl_i = '0; vsew_i = '0; vm_i = 1'b0;
    reversed_i = 1'b0; add_sub_i = 1'b0; compute_carry_i = 1'b0; with_carry_borrow_i = 1'b0;
    vs1_addr_i = '0; vs2_addr_i = '0; vd_addr_i = '0; vmask_i = '0; wb_ready_i = 1'b1;

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ready", 128'(issue_ready_o), 128'd1);
    chk("rst_rd_req", 128'(rd_req_o), 128'd0);
    rstn_i = 1'b1;
    @(negedge clk_i);
    chk("idle_ready", 128'(issue_ready_o), 128'd1);
    chk("idle_wb_valid", 128'(wb_valid_o), 128'd0);
    chk("idle_add_req", 128'(add_request_o), 128'd0);
    chk("idle_done", 128'(done_o), 128'd0);
    chk("idle_be", 128'(wb_be_o), 128'd0);

    // 8b add, one chunk, unmasked
    b_rd = n_rd; b_wb = n_wb; b_done = n_done;
    issue(8'd16, 2'b00, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3, '0);
    wait_done(b_done + 1, 40);
    chk("t1_nwb", 128'(n_wb - b_wb), 128'd1);
    chk("t1_nrd", 128'(n_rd - b_rd), 128'd1);
    chk("t1_ndone", 128'(n_done - b_done), 128'd1);
    chk("t1_chunk", 128'(wb_chunk_log[b_wb]), 128'd0);
    chk("t1_data", wb_data_log[b_wb], EXP_ADD8);
    chk("t1_be", 128'(wb_be_log[b_wb]), 128'hFFFF);
    chk("t1_vd", 128'(wb_vd_log[b_wb]), 128'd3);

    // 32b add, vl=10 -> three chunks, tail in chunk 2
    b_rd = n_rd; b_wb = n_wb; b_done = n_done;
    issue(8'd10, 2'b10, 1'b1, 1'b0, 5'd1, 5'd2, 5'd4, '0);
    wait_done(b_done + 1, 60);
    chk("t2_nwb", 128'(n_wb - b_wb), 128'd3);
    chk("t2_nrd", 128'(n_rd - b_rd), 128'd3);
    for (int i = 0; i < 3; i++) begin
      if (n_wb - b_wb > i) chk($sformatf("t2_wb_chunk%0d", i), 128'(wb_chunk_log[b_wb+i]), 128'(i));
      if (n_rd - b_rd > i) chk($sformatf("t2_rd_chunk%0d", i), 128'(rd_chunk_log[b_rd+i]), 128'(i));
    end
    if (n_wb - b_wb >= 3) begin
      chk("t2_be0", 128'(wb_be_log[b_wb]), 128'hFFFF);
      chk("t2_be1", 128'(wb_be_log[b_wb+1]), 128'hFFFF);
      chk("t2_be2", 128'(wb_be_log[b_wb+2]), 128'h00FF);
      chk("t2_data2", wb_data_log[b_wb+2], EXP_ADD32);
    end

    // Masked 8b add: only odd elements enabled
    b_wb = n_wb; b_done = n_done; k = vmask_log.size();
    issue(8'd16, 2'b00, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 128'h00AA);
    wait_done(b_done + 1, 40);
    chk("t3_nwb", 128'(n_wb - b_wb), 128'd1);
    chk("t3_be", 128'(wb_be_log[b_wb]), 128'h00AA);
    chk("t3_vmask", 128'(vmask_log[k]), 128'h00AA);

    // vmadc 64b vl=4, every element carries out
    b_rd = n_rd; b_wb = n_wb; b_done = n_done;
    issue(8'd4, 2'b11, 1'b1, 1'b1, 5'd8, 5'd8, 5'd5, '0);
    wait_done(b_done + 1, 40);
    chk("t4_nwb", 128'(n_wb - b_wb), 128'd1);
    chk("t4_nrd", 128'(n_rd - b_rd), 128'd2);
    chk("t4_chunk", 128'(wb_chunk_log[b_wb]), 128'd0);
    chk("t4_data", wb_data_log[b_wb], 128'hF);
    chk("t4_be", 128'(wb_be_log[b_wb]), 128'h0001);
    chk("t4_vd", 128'(wb_vd_log[b_wb]), 128'd5);

    // Writeback stall: outputs held while wb_ready_i is low
    wb_ready_i = 1'b0;
    b_wb = n_wb; b_done = n_done;
    issue(8'd16, 2'b00, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3, '0);
    k = 0;
    while (!wb_valid_o && k < 20) begin
      @(negedge clk_i);
      k++;
    end
    chk("t5_wb_seen", 128'(wb_valid_o), 128'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk($sformatf("t5_valid%0d", i), 128'(wb_valid_o), 128'd1);
      chk($sformatf("t5_data%0d", i), wb_data_o, EXP_ADD8);
      chk($sformatf("t5_be%0d", i), 128'(wb_be_o), 128'hFFFF);
    end
    chk("t5_no_done", 128'(n_done - b_done), 128'd0);
    @(posedge clk_i); #1;
    wb_ready_i = 1'b1;
    wait_done(b_done + 1, 20);
    chk("t5_nwb", 128'(n_wb - b_wb), 128'd1);

    // vl=0: done pulse only
    b_rd = n_rd; b_wb = n_wb; b_done = n_done;
    issue(8'd0, 2'b00, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3, '0);
    @(negedge clk_i);
    chk("t6_done_pulse", 128'(done_o), 128'd1);
    repeat (5) @(posedge clk_i);
    #1;
    chk("t6_nrd", 128'(n_rd - b_rd), 128'd0);
    chk("t6_nwb", 128'(n_wb - b_wb), 128'd0);
    chk("t6_ndone", 128'(n_done - b_done), 128'd1);
    chk("t6_ready", 128'(issue_ready_o), 128'd1);

    // Reset during EXEC of chunk 1 aborts the instruction
    b_rd = n_rd; b_done = n_done;
    issue(8'd10, 2'b10, 1'b1, 1'b0, 5'd1, 5'd2, 5'd6, '0);
    k = 0;
    while (!(add_request_o && (n_rd - b_rd) == 2) && k < 40) begin
      @(negedge clk_i);
      k++;
    end
    chk("t7_exec1", 128'(add_request_o && (n_rd - b_rd) == 2), 128'd1);
    rstn_i = 1'b0;
    #1;
    chk("t7_add_req", 128'(add_request_o), 128'd0);
    chk("t7_add_vs1", add_vs1_o, 128'd0);
    chk("t7_rd_req", 128'(rd_req_o), 128'd0);
    chk("t7_wb_valid", 128'(wb_valid_o), 128'd0);
    chk("t7_done", 128'(done_o), 128'd0);
    chk("t7_ready", 128'(issue_ready_o), 128'd1);
    b_wb = n_wb;
    repeat (2) @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    repeat (6) @(posedge clk_i);
    #1;
    chk("t7_no_wb", 128'(n_wb - b_wb), 128'd0);
    chk("t7_no_done", 128'(n_done - b_done), 128'd0);
    b_rd = n_rd; b_done = n_done;
    issue(8'd16, 2'b00, 1'b1, 1'b0, 5'd1, 5'd2, 5'd7, '0);
    wait_done(b_done + 1, 40);
    chk("t7_nwb", 128'(n_wb - b_wb), 128'd1);
    if (n_rd > b_rd) chk("t7_rd_chunk", 128'(rd_chunk_log[b_rd]), 128'd0);
    if (n_wb > b_wb) begin
      chk("t7_wb_chunk", 128'(wb_chunk_log[b_wb]), 128'd0);
      chk("t7_data", wb_data_log[b_wb], EXP_ADD8);
      chk("t7_vd", 128'(wb_vd_log[b_wb]), 128'd7);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
